oam_dma: RTL and testbench
==========================

# oam_dma

Sprite OAM DMA engine and bus-master mux sitting directly downstream of the 6502 core's external bus (`o_rw`, `o_address`, `o_data`) and upstream of the NES memory map. While idle it passes CPU bus cycles through unchanged. A CPU write to $4014 halts the CPU and copies 256 bytes from page `{data,8'h00}` to the PPU OAMDATA port ($2004) as alternating read/write cycles, then returns the bus to the CPU.

## Interface
Parameters:
- `DMA_TRIGGER_ADDR`, default 16'h4014, address whose CPU write starts DMA
- `OAM_DATA_ADDR`, default 16'h2004, destination address for every DMA write

Ports:
- `i_clk`  in  1  system clock; all state changes on posedge
- `i_reset_n`  in  1  asynchronous, active-low reset
- `i_cpu_rw`  in  1  CPU read/write, 1 = READ, 0 = WRITE
- `i_cpu_address`  in  16  CPU address
- `i_cpu_data`  in  8  CPU write data
- `i_bus_data`  in  8  read data returned from the memory map
- `o_rw`  out  1  muxed bus read/write
- `o_address`  out  16  muxed bus address
- `o_data`  out  8  muxed bus write data
- `o_cpu_rdy`  out  1  1 = CPU may advance; 0 = CPU must stall
- `o_busy`  out  1  1 while any DMA state is active

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- `r_parity` toggles every clock; reset value 0. "Even cycle" means `r_parity`==0 during that cycle.
- IDLE: `o_rw/o_address/o_data` = `i_cpu_*` combinationally; `o_cpu_rdy`=1, `o_busy`=0. If `i_cpu_rw`==0 and `i_cpu_address`==DMA_TRIGGER_ADDR at a posedge: latch `r_page`=`i_cpu_data`, `r_count`=0, go HALT. A read of $4014 (rw=1) does nothing.
- HALT (1 cycle): go READ if next cycle is even, else ALIGN.
- ALIGN (1 cycle): go READ.
- HALT/ALIGN bus: `o_rw`=1, `o_address`={`r_page`,8'h00}, `o_data`=8'h00, data ignored.
- READ: `o_rw`=1, `o_address`={`r_page`,`r_count`}; at posedge latch `r_byte`=`i_bus_data`; go WRITE.
- WRITE: `o_rw`=0, `o_address`=OAM_DATA_ADDR, `o_data`=`r_byte`; at posedge `r_count`+=1 (8-bit). If `r_count` was 8'hFF go IDLE, else READ.
- In all non-IDLE states: `o_cpu_rdy`=0, `o_busy`=1; CPU inputs ignored, including further $4014 writes.
- Source address never crosses the page: `r_page` is fixed, `r_count` wraps 8'hFF->8'h00 exactly once, at termination.

## Timing
- Reset (async, any state): state=IDLE, `r_parity`=0, `r_page`=0, `r_count`=0, `r_byte`=0; therefore `o_cpu_rdy`=1, `o_busy`=0, outputs track CPU inputs. Reset mid-DMA aborts with no further $2004 writes.
- Trigger write cycle T is a normal CPU bus cycle. Stall begins at T+1.
- Stall length: 513 cycles if T+2 is even (HALT, 256×READ/WRITE), else 514 (HALT, ALIGN, ...).
- First READ always on an even cycle; each READ->WRITE pair is exactly 2 cycles; no gaps.
- `o_cpu_rdy` and `o_busy` decode registered state only; no combinational path from CPU inputs.
- First CPU cycle after DMA: the cycle after the final WRITE.

## Configuration
- `OAM_DMA_ALIGN_EN` defined: parity-based ALIGN cycle as above (513/514 cycles).
- Undefined: ALIGN state and `r_parity` removed; HALT always goes to READ; stall is always 513 cycles.

## Test plan
- Pass-through: CPU read $8000, write 8'h5A to $0300 -> identical `o_*`, `o_cpu_rdy`=1 throughout.
- Page $02 holding 8'h00..8'hFF, write 8'h02 to $4014 -> 256 writes to $2004 with data 8'h00..8'hFF in order, reads at $0200..$02FF, `o_cpu_rdy` returns to 1.
- Trigger with T+2 even, then with T+2 odd -> `o_cpu_rdy` low exactly 513 vs 514 cycles (both 513 without the macro).
- Page $FF -> last read at $FFFF, no access at $0000; engine then idle.
- Assert `i_reset_n`=0 after 100 DMA writes -> immediate IDLE, `o_cpu_rdy`=1, no further $2004 writes; following $4014 write restarts from `r_count`=0.
- CPU read of $4014, and $4014 write attempted during DMA -> no DMA started/restarted; transfer count stays 256.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine and bus-master mux between the 6502 core and the memory map.
// Define OAM_DMA_ALIGN_EN to enable the parity-based ALIGN cycle (513/514-cycle stall).
module oam_dma #(
  parameter logic [15:0] DMA_TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR    = 16'h2004
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_cpu_rdy,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
`ifdef OAM_DMA_ALIGN_EN
    S_ALIGN,
`endif
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q,  page_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  byte_q,  byte_d;

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) parity_q <= 1'b0;
    else            parity_q <= ~parity_q;
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      count_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      count_q <= count_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    count_d   = count_q;
    byte_d    = byte_q;
    o_rw      = 1'b1;
    o_address = {page_q, 8'h00};
    o_data    = '0;
    unique case (state_q)
      S_IDLE: begin
        o_rw      = i_cpu_rw;
        o_address = i_cpu_address;
        o_data    = i_cpu_data;
        if (!i_cpu_rw && (i_cpu_address == DMA_TRIGGER_ADDR)) begin
          page_d  = i_cpu_data;
          count_d = '0;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // parity_q is odd now, so the following cycle is even and READ can start
        state_d = parity_q ? S_READ : S_ALIGN;
`else
        state_d = S_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      S_ALIGN: state_d = S_READ;
`endif
      S_READ: begin
        o_address = {page_q, count_q};
        byte_d    = i_bus_data;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        o_rw      = 1'b0;
        o_address = OAM_DATA_ADDR;
        o_data    = byte_q;
        count_d   = count_q + 8'd1;
        state_d   = (count_q == 8'hFF) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_cpu_rdy = (state_q == S_IDLE);
  assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: cycle-level reference model plus directed literal checks.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [7:0]  bus_data;
  logic        o_rw;
  logic [15:0] o_address;
  logic [7:0]  o_data;
  logic        o_cpu_rdy;
  logic        o_busy;

  oam_dma #(.DMA_TRIGGER_ADDR(16'h4014), .OAM_DATA_ADDR(16'h2004)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cpu_rw(cpu_rw), .i_cpu_address(cpu_addr),
    .i_cpu_data(cpu_data), .i_bus_data(bus_data), .o_rw(o_rw), .o_address(o_address),
    .o_data(o_data), .o_cpu_rdy(o_cpu_rdy), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Memory contents: page $02 holds its own low address byte.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h02;
  endfunction

  assign bus_data = mem_f(o_address);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: dj = cycle offset inside the stall (-1 when idle).
  int          cyc = 0;
  int          dj  = -1;
  int          dL  = 513;
  logic [7:0]  dpage = '0;

  int          stall_cnt  = 0;
  int          last_stall = 0;
  int          wr_cnt     = 0;
  logic [7:0]  wr_q[$];
  logic [15:0] last_rd = '0;
  bit          saw_zero = 0;

  always @(negedge clk) begin
    logic        e_rw;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    bit          chk_data;
    int          off, k;
    if (!rst_n) begin
      dj = -1;
      cyc = 0;
      stall_cnt = 0;
      check("rst_rw",   o_rw, cpu_rw);
      check("rst_addr", o_address, cpu_addr);
      check("rst_rdy",  o_cpu_rdy, 1);
      check("rst_busy", o_busy, 0);
    end else begin
      chk_data = 1;
      e_data = 8'h00;
      if (dj < 0) begin
        e_rw = cpu_rw; e_addr = cpu_addr; e_data = cpu_data;
      end else begin
        off = dL - 512;
        if (dj < off) begin
          e_rw = 1'b1; e_addr = {dpage, 8'h00};
        end else begin
          k = dj - off;
          if (k % 2 == 0) begin
            e_rw = 1'b1; e_addr = {dpage, 8'(k / 2)}; chk_data = 0;
          end else begin
            e_rw = 1'b0; e_addr = 16'h2004; e_data = mem_f({dpage, 8'(k / 2)});
          end
        end
      end
      check("cmp_rw",   o_rw, e_rw);
      check("cmp_addr", o_address, e_addr);
      if (chk_data) check("cmp_data", o_data, e_data);
      check("cmp_rdy",  o_cpu_rdy, (dj < 0) ? 1 : 0);
      check("cmp_busy", o_busy,    (dj < 0) ? 0 : 1);

      if (o_busy && !o_rw && o_address == 16'h2004) begin
        wr_cnt++;
        wr_q.push_back(o_data);
      end
      if (o_busy && o_rw) last_rd = o_address;
      if (o_busy && o_address == 16'h0000) saw_zero = 1;
      if (!o_cpu_rdy) stall_cnt++;
      else if (stall_cnt != 0) begin
        last_stall = stall_cnt;
        stall_cnt = 0;
      end

      if (dj < 0) begin
        if (!cpu_rw && cpu_addr == 16'h4014) begin
          dpage = cpu_data;
`ifdef OAM_DMA_ALIGN_EN
          dL = (cyc % 2 == 0) ? 513 : 514;
`else
          dL = 513;
`endif
          dj = 0;
        end
      end else begin
        dj++;
        if (dj == dL) dj = -1;
      end
      cyc++;
    end
  end

  task automatic cpu(input logic rw, input logic [15:0] a, input logic [7:0] d);
    cpu_rw = rw; cpu_addr = a; cpu_data = d;
    @(posedge clk); #1;
  endtask

  task automatic trigger(input logic [7:0] page, input int par);
    for (int i = 0; i < 4 && (cyc % 2) != par; i++) cpu(1'b1, 16'h8000, 8'h00);
    wr_cnt = 0; wr_q.delete(); saw_zero = 0; last_rd = '0;
    cpu(1'b0, 16'h4014, page);
    cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_data = 8'h00;
  endtask

  task automatic wait_done(input bit hold_trig);
    for (int i = 0; i < 700 && !o_cpu_rdy; i++) begin
      if (hold_trig) begin
        cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_data = 8'h33;
      end else begin
        cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_data = 8'h00;
      end
      @(posedge clk); #1;
    end
    cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_data = 8'h00;
    check("dma_done", o_cpu_rdy, 1);
    @(posedge clk); #1;
  endtask

  int exp_odd;

  initial begin
    rst_n = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_data = 8'h00;
`ifdef OAM_DMA_ALIGN_EN
    exp_odd = 514;
`else
    exp_odd = 513;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", o_cpu_rdy, 1);
    check("reset_busy", o_busy, 0);
    rst_n = 1'b1;

    cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_data = 8'h00; #1;
    check("pt_rd_addr", o_address, 16'h8000);
    check("pt_rd_rw", o_rw, 1);
    @(posedge clk); #1;
    cpu_rw = 1'b0; cpu_addr = 16'h0300; cpu_data = 8'h5A; #1;
    check("pt_wr_addr", o_address, 16'h0300);
    check("pt_wr_data", o_data, 8'h5A);
    check("pt_wr_rw", o_rw, 0);
    check("pt_rdy", o_cpu_rdy, 1);
    @(posedge clk); #1;

    trigger(8'h02, 0);
    check("halt_rdy", o_cpu_rdy, 0);
    wait_done(0);
    check("even_cnt", wr_cnt, 256);
    check("even_d0", wr_q[0], 8'h00);
    check("even_d128", wr_q[128], 8'h80);
    check("even_d255", wr_q[255], 8'hFF);
    check("even_lastrd", last_rd, 16'h02FF);
    check("even_stall", last_stall, 513);

    trigger(8'h02, 1);
    wait_done(0);
    check("odd_cnt", wr_cnt, 256);
    check("odd_stall", last_stall, exp_odd);

    trigger(8'hFF, 0);
    wait_done(0);
    check("ff_lastrd", last_rd, 16'hFFFF);
    check("ff_zero", saw_zero, 0);
    check("ff_d255", wr_q[255], 8'h02);
    check("ff_idle", o_busy, 0);

    wr_cnt = 0;
    cpu(1'b1, 16'h4014, 8'h02);
    cpu(1'b1, 16'h8000, 8'h00);
    check("rd4014_busy", o_busy, 0);
    check("rd4014_cnt", wr_cnt, 0);

    trigger(8'h02, 0);
    wait_done(1);
    check("retrig_cnt", wr_cnt, 256);

    trigger(8'h02, 0);
    for (int i = 0; i < 400 && wr_cnt < 100; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; #1;
    check("abort_rdy", o_cpu_rdy, 1);
    check("abort_busy", o_busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) cpu(1'b1, 16'h8000, 8'h00);
    check("abort_cnt", wr_cnt, 100);
    trigger(8'h02, 0);
    wait_done(0);
    check("restart_cnt", wr_cnt, 256);
    check("restart_d0", wr_q[0], 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
